// File: rtl/cp0_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_if
// Description : M-stage exception and CP0 access bundle between the pipeline
//               (master) and the coprocessor-0 responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_if;
  logic [31:0] PC_M;
  logic        Delay_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic [4:0]  CP0_A;
  logic [31:0] CP0_Din;
  logic        CP0_We;
  logic        EXLClr;
  logic [31:0] CP0_Dout;
  logic        Req;
  logic [31:0] ExcPC;
  logic [31:0] EPC_out;

  modport master (
    output PC_M, Delay_M, ExcCode_M, HWInt, CP0_A, CP0_Din, CP0_We, EXLClr,
    input  CP0_Dout, Req, ExcPC, EPC_out
  );

  modport slave (
    input  PC_M, Delay_M, ExcCode_M, HWInt, CP0_A, CP0_Din, CP0_We, EXLClr,
    output CP0_Dout, Req, ExcPC, EPC_out
  );
endinterface
`default_nettype wire

// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
// Module      : cp0
// Description : Coprocessor-0 exception/interrupt responder (SR, Cause, EPC)
//               with zero-cycle flush request. Define CP0_PRID_EN to expose
//               the PRId register at index 15.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0 #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  wire logic clk,
  input  wire logic reset,
  cp0_if.slave      bus
);

`ifdef CP0_PRID_EN
  localparam logic [31:0] PRID = 32'h2022_0007;
`endif

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_dout;

  // Gating with reset keeps Req low for the whole asynchronous reset window.
  assign w_int_req = (|(bus.HWInt & r_im)) & r_ie & ~r_exl & reset;
  assign w_exc_req = (bus.ExcCode_M != 5'd0) & ~r_exl & reset;
  assign w_req     = w_int_req | w_exc_req;

  assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_req) begin
        // The M-stage instruction is being flushed, so its mtc0/eret are dropped.
        r_exl      <= 1'b1;
        r_bd       <= bus.Delay_M;
        r_exc_code <= w_int_req ? 5'd0 : bus.ExcCode_M;
        r_epc      <= bus.Delay_M ? (bus.PC_M - 32'd4) : bus.PC_M;
      end else begin
        if (bus.CP0_We) begin
          case (bus.CP0_A)
            5'd12: begin
              r_im  <= bus.CP0_Din[15:10];
              r_exl <= bus.CP0_Din[1];
              r_ie  <= bus.CP0_Din[0];
            end
            5'd14:   r_epc <= bus.CP0_Din;
            default: ;
          endcase
        end
        // Placed after the mtc0 so eret wins the EXL bit on a collision.
        if (bus.EXLClr) r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    w_dout = 32'd0;
    case (bus.CP0_A)
      5'd12:   w_dout = w_sr;
      5'd13:   w_dout = w_cause;
      5'd14:   w_dout = r_epc;
`ifdef CP0_PRID_EN
      5'd15:   w_dout = PRID;
`endif
      default: w_dout = 32'd0;
    endcase
  end

  assign bus.CP0_Dout = w_dout;
  assign bus.Req      = w_req;
  assign bus.ExcPC    = w_req ? EXC_VECTOR : r_epc;
  assign bus.EPC_out  = r_epc;

endmodule
`default_nettype wire

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt responder for the five-stage MIPS pipeline. It consumes the M-stage exception fields (`Delay`, `ExcCode`, PC) carried by the E→M pipeline register, and merges them with external hardware interrupts. It raises `Req`, which flushes every pipeline register on the next clock edge. On that same edge it captures SR/Cause/EPC state, and it serves `mfc0`/`mtc0`/`eret` from the M stage.

## Interface
- `EXC_VECTOR`, 32'h0000_4180, handler entry PC driven on `ExcPC` while `Req`=1
- `PRID`, 32'h2022_0007, value returned for register 15 (see Configuration)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, asynchronous and active-low; one clock domain
- `PC_M`  in  32  PC of the instruction currently in M
- `Delay_M`  in  1  instruction in M sits in a branch delay slot
- `ExcCode_M`  in  5  exception code accumulated through F/D/E/M; 0 = none
- `HWInt`  in  6  external interrupt lines, level-sensitive
- `CP0_A`  in  5  CP0 register index for `mfc0`/`mtc0`
- `CP0_Din`  in  32  `mtc0` write data
- `CP0_We`  in  1  `mtc0` in M
- `EXLClr`  in  1  `eret` in M
- `CP0_Dout`  out  32  combinational read of the register selected by `CP0_A`
- `Req`  out  1  flush/redirect request to all pipeline registers and the PC
- `ExcPC`  out  32  `EXC_VECTOR` when `Req`=1, else EPC
- `EPC_out`  out  32  current EPC (eret target)

## Operation
- State registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): 32 bits.
- `IntReq` = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- `ExcReq` = (ExcCode_M != 0) & ~SR.EXL.
- `Req` = `IntReq | ExcReq`; it is combinational from current state and inputs.
- Interrupt has priority over a synchronous exception in the same cycle.
- Every clock edge: Cause.IP <= HWInt (free-running sample).
- Edge with `Req`=1:
  - SR.EXL <= 1.
  - Cause.BD <= Delay_M.
  - Cause.ExcCode <= IntReq ? 0 : ExcCode_M.
  - EPC <= Delay_M ? PC_M − 4 : PC_M, modulo 2^32.
  - `mtc0` and `EXLClr` in the same cycle are ignored, because the instruction is being flushed.
- Edge with `Req`=0:
  - If `CP0_We`: write SR (IM, EXL, IE only), EPC (full 32 bits), or Cause (no writable fields; write ignored).
  - If `EXLClr`: SR.EXL <= 0. If a `mtc0` to SR coincides, `EXLClr` wins for EXL.
- Writes to any index other than 12/14 are ignored. Reads of unimplemented indices return 0.
- `CP0_Dout` returns the pre-edge value during a same-cycle write; there is no write-through bypass.

## Timing
- Reset (`reset`=0, asynchronous): SR=0, Cause=0, EPC=0. `Req` is forced to 0 while reset is low, then `ExcPC`=0 and `EPC_out`=0.
- Zero-cycle decision:
  - `Req` is valid in the same cycle the faulting instruction occupies M.
  - Pipeline registers flush on that edge.
  - The PC loads `ExcPC` on that edge.
- One `Req` pulse per event: after the edge, EXL=1 masks both request terms. Nested exceptions are not taken until `eret`.
- Interrupt latency: `HWInt` rising with IE=1, IM=1, EXL=0 gives `Req`=1 in the same cycle. Cause.IP reflects it one edge later.
- Bubbles (ExcCode_M=0, PC_M=0) never raise `ExcReq`. A bubble may still take an interrupt; EPC=0 is then the software-visible result.
- Reset asserted mid-handler clears EXL immediately; `Req` stays 0 until reset releases.

## Configuration
- `CP0_PRID_EN`
  - Defined: index 15 reads `PRID`; writes to it are ignored.
  - Undefined: index 15 reads 0; no PRId logic is present.

## Test plan
- Reset release, then `mfc0` 12/13/14 → all read 0, `Req`=0, `ExcPC`=0.
- `mtc0` SR=32'h0000_0401, then `HWInt`=6'b000001, PC_M=32'h3010, Delay_M=0 → `Req`=1 that cycle and `ExcPC`=32'h4180. After the edge: EPC=32'h3010, Cause.ExcCode=0, SR.EXL=1, `Req`=0.
- ExcCode_M=5'd10, PC_M=32'h3024, Delay_M=1, EXL=0 → `Req`=1. After the edge: EPC=32'h3020, Cause=32'h8000_0028.
- Interrupt and ExcCode_M=5'd4 in the same cycle with IE=1, IM hit → Cause.ExcCode=0; interrupt wins.
- EXL=1 with ExcCode_M=5'd12 → `Req`=0. Then `EXLClr`=1 → EXL=0 next edge; `EPC_out` is unchanged and drives the eret target.
- `mtc0` SR and interrupt in the same cycle → write dropped (SR.IM unchanged), EXL=1. With `CP0_PRID_EN`, `mfc0` 15 reads 32'h2022_0007; without it, reads 0.
